// File: rtl/aes_decipher.sv
// -----------------------------------------------------------------------------
// aes_decipher
//
// Iterative AES inverse cipher (FIPS-197 InvCipher) for AES-128 and AES-256.
// It runs one round per clock. Round keys come from an external key store: the
// core drives the round index, and the store returns that round's key
// combinationally in the same cycle.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   next       start request, honoured only while ready=1
//   keylen     0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds), latched at start
//   round      index of the round key requested this cycle
//   round_key  key for index `round` (combinational lookup in the key store)
//   block      ciphertext, sampled on the accepted start edge
//   new_block  plaintext result, valid while ready=1 after an operation
//   ready      1 = idle / result valid, 0 = busy
//
// State layout: bits [127:120] = s(0,0). Column c occupies [127-32c -: 32], and
// row r is byte r within its column.
// -----------------------------------------------------------------------------
module aes_decipher #(
    parameter int AES128_ROUNDS = 10,
    parameter int AES256_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    localparam logic [3:0] NR128 = 4'(AES128_ROUNDS);
    localparam logic [3:0] NR256 = 4'(AES256_ROUNDS);

    // Inverse S-box. Index 0 is the leftmost byte.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {CTRL_IDLE, CTRL_MAIN, CTRL_FINAL} ctrl_e;

    // ---------------------------------------------------------------- functions
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a constant of at most 4 bits (0x09, 0x0b, 0x0d, 0x0e).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_column(s[127:96]), inv_mix_column(s[95:64]),
                inv_mix_column(s[63:32]),  inv_mix_column(s[31:0])};
    endfunction

    // Rotate row r right by r, so s'(r,c) = s(r,(c-r) mod 4).
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = INV_SBOX[s[8*i +: 8]];
        return o;
    endfunction

    // ---------------------------------------------------------------- state
    ctrl_e        ctrl_reg, ctrl_next;
    logic [127:0] block_reg, block_next;
    logic [3:0]   round_ctr, round_ctr_next;
    logic         keylen_reg, keylen_next;
    logic         ready_reg, ready_next;

    logic [3:0]   nr_start;
    logic [127:0] inv_sb_sr;

    assign nr_start  = keylen ? NR256 : NR128;
    assign inv_sb_sr = inv_sub_bytes(inv_shift_rows(block_reg));

    assign new_block = block_reg;
    assign ready     = ready_reg;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) ctrl_reg <= CTRL_IDLE;
        else     ctrl_reg <= ctrl_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: each signal assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and infers a latch.
        ctrl_next = ctrl_reg;
        unique case (ctrl_reg)
            CTRL_IDLE:  if (next) ctrl_next = CTRL_MAIN;
            CTRL_MAIN:  if (round_ctr == 4'd1) ctrl_next = CTRL_FINAL;
            CTRL_FINAL: ctrl_next = CTRL_IDLE;
            default:    ctrl_next = CTRL_IDLE;
        endcase
    end

    // Output and datapath logic.
    always_comb begin
        round          = round_ctr;
        block_next     = block_reg;
        round_ctr_next = round_ctr;
        keylen_next    = keylen_reg;
        ready_next     = ready_reg;
        unique case (ctrl_reg)
            CTRL_IDLE: begin
                // While idle, the core asks for the initial key of a possible start.
                round = nr_start;
                if (next) begin
                    block_next     = block ^ round_key;
                    keylen_next    = keylen;
                    round_ctr_next = nr_start - 4'd1;
                    ready_next     = 1'b0;
                end
            end
            CTRL_MAIN: begin
                // The key is added before InvMixColumns (InvCipher ordering).
                block_next     = inv_mix_columns(inv_sb_sr ^ round_key);
                round_ctr_next = round_ctr - 4'd1;  // reaches 0 on entry to FINAL
            end
            CTRL_FINAL: begin
                round      = 4'd0;
                block_next = inv_sb_sr ^ round_key;
                ready_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            block_reg  <= '0;
            round_ctr  <= '0;
            keylen_reg <= 1'b0;
            ready_reg  <= 1'b1;
        end else begin
            block_reg  <= block_next;
            round_ctr  <= round_ctr_next;
            keylen_reg <= keylen_next;
            ready_reg  <= ready_next;
        end
    end

endmodule

// File: tb/tb_aes_decipher.sv
// -----------------------------------------------------------------------------
// tb_aes_decipher
//
// Self-checking bench for aes_decipher. The bench models the key store: it
// expands the key into rk_mem, and the core reads rk_mem[round] combinationally.
// The reference model builds the S-box from GF(2^8) inversion plus the affine
// map. It encrypts random plaintexts with the forward cipher, and the core
// must recover each plaintext. The FIPS-197 vectors anchor the known answers.
// -----------------------------------------------------------------------------
module tb_aes_decipher;

    logic         clk = 1'b0;
    logic         rst;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk_mem [0:15];
    logic [7:0]   sbox   [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_decipher dut (
        .clk       (clk),
        .rst       (rst),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    assign round_key = rk_mem[round];

    // ---------------------------------------------------------------- model
    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = '0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = m_xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = m_gmul(inv, 8'(x));
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Key expansion into the key store. An AES-128 key sits in key[255:128].
    task automatic load_keys(input logic [255:0] key, input logic kl);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = m_xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Forward cipher on a byte array, where s[4c+r] is row r of column c.
    task automatic model_encrypt(input logic [127:0] pt, input logic kl, output logic [127:0] ct);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [7:0] a0, a1, a2, a3;
        int nr;
        nr = kl ? 14 : 10;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk_mem[0][127 - 8*i -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c + r] = s[4*((c + r) % 4) + r];
            if (rd != nr) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = m_gmul(a0, 8'h02) ^ m_gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ m_gmul(a1, 8'h02) ^ m_gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ m_gmul(a2, 8'h02) ^ m_gmul(a3, 8'h03);
                    t[4*c+3] = m_gmul(a0, 8'h03) ^ a1 ^ a2 ^ m_gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk_mem[rd][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
    endtask

    // ---------------------------------------------------------------- driver
    // Starts one operation and follows it until ready returns high. lat counts
    // posedges, including the start edge. trace_ok reports whether the core
    // presented round indices Nr..0 in order. If disturb_at > 0, the bench
    // pulses next, flips keylen and changes block after that many edges.
    task automatic do_op(input logic kl, input logic [127:0] ct, input int disturb_at,
                         output int lat, output bit trace_ok, output logic [127:0] res);
        int exp_r;
        @(negedge clk);
        next = 1'b1; keylen = kl; block = ct;
        #1;
        exp_r = kl ? 14 : 10;
        trace_ok = (round === 4'(exp_r));
        @(posedge clk); #1;
        next = 1'b0;
        lat  = 1;
        while (ready !== 1'b1 && lat < 40) begin
            exp_r--;
            if (round !== 4'(exp_r)) trace_ok = 1'b0;
            if (disturb_at > 0 && lat == disturb_at) begin
                next = 1'b1; keylen = ~kl; block = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                next = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        next = 1'b0;
        if (exp_r != 0) trace_ok = 1'b0;
        res = new_block;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_checks++; if (new_block !== 128'h0) begin n_fail++; $display("FAIL reset_block: got %h want 0", new_block); end
        n_checks++; if (round !== 4'd10) begin n_fail++; $display("FAIL reset_round128: got %0d want 10", round); end
        keylen = 1'b1; #1;
        n_checks++; if (round !== 4'd14) begin n_fail++; $display("FAIL reset_round256: got %0d want 14", round); end
        keylen = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_aes128();
        int lat; bit tr; logic [127:0] res;
        load_keys(KEY128, 1'b0);
        do_op(1'b0, CT_C1, 0, lat, tr, res);
        n_checks++; if (lat != 11) begin n_fail++; $display("FAIL c1_latency: got %0d want 11", lat); end
        n_checks++; if (!tr) begin n_fail++; $display("FAIL c1_round_trace: got bad sequence want 10..0"); end
        n_checks++; if (res !== PT_FIPS) begin n_fail++; $display("FAIL c1_result: got %h want %h", res, PT_FIPS); end
        // The result must hold while idle, even when the inputs wander.
        block = {$urandom, $urandom, $urandom, $urandom}; keylen = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (new_block !== PT_FIPS || ready !== 1'b1) begin
            n_fail++; $display("FAIL c1_hold: got %h/%b want %h/1", new_block, ready, PT_FIPS);
        end
    endtask

    task automatic test_aes256();
        int lat; bit tr; logic [127:0] res;
        load_keys(KEY256, 1'b1);
        do_op(1'b1, CT_C3, 0, lat, tr, res);
        n_checks++; if (lat != 15) begin n_fail++; $display("FAIL c3_latency: got %0d want 15", lat); end
        n_checks++; if (!tr) begin n_fail++; $display("FAIL c3_round_trace: got bad sequence want 14..0"); end
        n_checks++; if (res !== PT_FIPS) begin n_fail++; $display("FAIL c3_result: got %h want %h", res, PT_FIPS); end
    endtask

    task automatic test_busy_immunity();
        int lat; bit tr; logic [127:0] res;
        load_keys(KEY128, 1'b0);
        do_op(1'b0, CT_C1, 5, lat, tr, res);
        n_checks++; if (lat != 11) begin n_fail++; $display("FAIL busy_latency: got %0d want 11", lat); end
        n_checks++; if (!tr) begin n_fail++; $display("FAIL busy_round_trace: got bad sequence want 10..0"); end
        n_checks++; if (res !== PT_FIPS) begin n_fail++; $display("FAIL busy_result: got %h want %h", res, PT_FIPS); end
    endtask

    task automatic test_reset_mid_op();
        int lat; bit tr; logic [127:0] res;
        load_keys(KEY256, 1'b1);
        @(negedge clk);
        next = 1'b1; keylen = 1'b1; block = CT_C3;
        @(posedge clk); #1;
        next = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", ready); end
        n_checks++; if (new_block !== 128'h0) begin n_fail++; $display("FAIL midrst_block: got %h want 0", new_block); end
        n_checks++; if (round !== 4'd14) begin n_fail++; $display("FAIL midrst_idle_round: got %0d want 14", round); end
        rst = 1'b0;
        load_keys(KEY128, 1'b0);
        do_op(1'b0, CT_C1, 0, lat, tr, res);
        n_checks++; if (res !== PT_FIPS || lat != 11) begin
            n_fail++; $display("FAIL midrst_rerun: got %h lat %0d want %h lat 11", res, lat, PT_FIPS);
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2;
        logic prev_ready;
        logic [127:0] res1, res2;
        e1 = 0; e2 = 0; res1 = '0; res2 = '0;
        load_keys(KEY128, 1'b0);
        @(negedge clk);
        next = 1'b1; keylen = 1'b0; block = CT_C1;
        prev_ready = ready;
        for (int e = 1; e <= 40 && e2 == 0; e++) begin
            @(posedge clk); #1;
            if (ready === 1'b1 && prev_ready !== 1'b1) begin
                if (e1 == 0) begin
                    e1 = e; res1 = new_block;
                    // The second start is taken at the next edge, so the key
                    // store must already serve the AES-256 schedule.
                    load_keys(KEY256, 1'b1);
                    keylen = 1'b1; block = CT_C3;
                end else begin
                    e2 = e; res2 = new_block;
                    next = 1'b0;
                end
            end
            prev_ready = ready;
        end
        next = 1'b0;
        n_checks++; if (e1 != 11) begin n_fail++; $display("FAIL b2b_edge1: got %0d want 11", e1); end
        n_checks++; if (res1 !== PT_FIPS) begin n_fail++; $display("FAIL b2b_result1: got %h want %h", res1, PT_FIPS); end
        n_checks++; if (e2 != 26) begin n_fail++; $display("FAIL b2b_edge2: got %0d want 26", e2); end
        n_checks++; if (res2 !== PT_FIPS) begin n_fail++; $display("FAIL b2b_result2: got %h want %h", res2, PT_FIPS); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (new_block !== PT_FIPS || ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_hold: got %h/%b want %h/1", new_block, ready, PT_FIPS);
        end
    endtask

    task automatic test_loopback();
        logic [255:0] key;
        logic [127:0] pt, ct, res;
        logic kl;
        int lat; bit tr;
        for (int n = 0; n < 1000; n++) begin
            kl  = 1'($urandom_range(0, 1));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (!kl) key[127:0] = '0;
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_keys(key, kl);
            model_encrypt(pt, kl, ct);
            do_op(kl, ct, 0, lat, tr, res);
            n_checks++; if (res !== pt) begin
                n_fail++; $display("FAIL loopback_result[%0d] kl=%b: got %h want %h", n, kl, res, pt);
            end
            n_checks++; if (lat != (kl ? 15 : 11) || !tr) begin
                n_fail++; $display("FAIL loopback_timing[%0d] kl=%b: got lat %0d trace %b want lat %0d trace 1",
                                   n, kl, lat, tr, kl ? 15 : 11);
            end
        end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        rst = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
        for (int r = 0; r < 16; r++) rk_mem[r] = '0;
        build_sbox();
        test_reset();
        test_aes128();
        test_aes256();
        test_busy_immunity();
        test_reset_mid_op();
        test_back_to_back();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
